// File: rtl/ariane_pkg.sv
// Shared core types: the dcache request/response pair used by the store path.
package ariane_pkg;

   typedef struct packed {
      logic [11:0] address_index;
      logic [43:0] address_tag;
      logic [63:0] data_wdata;
      logic        data_req;
      logic        data_we;
      logic [7:0]  data_be;
      logic [1:0]  data_size;
      logic        kill_req;
      logic        tag_valid;
   } dcache_req_i_t;

   typedef struct packed {
      logic        data_gnt;
      logic        data_rvalid;
      logic [63:0] data_rdata;
   } dcache_req_o_t;

endpackage

// File: rtl/std_cache_pkg.sv
// Store-queue entry layout and default depth for the standard cache subsystem.
package std_cache_pkg;

   localparam int unsigned DEFAULT_SQ_DEPTH = 4;

   typedef struct packed {
      logic [55:0] paddr;
      logic [63:0] data;
      logic [7:0]  be;
      logic [1:0]  size;
   } sq_entry_t;

endpackage

// File: rtl/store_commit_queue.sv
// Store queue holding speculative and committed stores; committed stores drain
// oldest-first to the dcache through a request phase followed by a one-cycle tag phase.
module store_commit_queue
   import ariane_pkg::*;
   import std_cache_pkg::*;
#(
   parameter int unsigned DEPTH = DEFAULT_SQ_DEPTH
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          flush_i,
   input  logic          valid_i,
   input  logic [55:0]   paddr_i,
   input  logic [63:0]   data_i,
   input  logic [7:0]    be_i,
   input  logic [1:0]    data_size_i,
   output logic          ready_o,
   input  logic          commit_i,
   output logic          empty_o,
   input  logic [11:0]   page_offset_i,
   output logic          page_offset_matches_o,
   output dcache_req_i_t req_port_o,
   input  dcache_req_o_t req_port_i,
   output logic [1:0]    drain_state_o
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] REQ  = 2'd1;
   localparam logic [1:0] TAG  = 2'd2;

   sq_entry_t     mem [DEPTH];
   logic [PW-1:0] read_ptr, commit_ptr, write_ptr;
   logic [PW-1:0] commit_ptr_d;
   logic [PW:0]   commit_cnt, spec_cnt, commit_cnt_d, occupancy;
   logic [1:0]    state_q, state_d;
   logic          push, commit, pop;
   sq_entry_t     head;
   logic          unused_rsp;

   assign occupancy    = commit_cnt + spec_cnt;
   assign ready_o      = occupancy < DEPTH_C;
   assign push         = valid_i && ready_o && !flush_i;
   assign commit       = commit_i && (spec_cnt != '0);
   assign pop          = (state_q == TAG);
   assign commit_ptr_d = commit_ptr + PW'(commit);
   assign commit_cnt_d = commit_cnt + (PW+1)'(commit) - (PW+1)'(pop);
   assign head         = mem[read_ptr];
   assign empty_o      = (commit_cnt == '0) && (spec_cnt == '0) && (state_q == IDLE);
   assign drain_state_o = state_q;
   assign unused_rsp   = ^{req_port_i.data_rvalid, req_port_i.data_rdata, page_offset_i[2:0]};

   always_ff @(posedge clk_i) begin
      if (push) mem[write_ptr] <= '{paddr: paddr_i, data: data_i, be: be_i, size: data_size_i};
   end

   // Flush rewinds the write pointer to the commit boundary after any same-cycle commit.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         read_ptr   <= '0;
         commit_ptr <= '0;
         write_ptr  <= '0;
         commit_cnt <= '0;
         spec_cnt   <= '0;
         state_q    <= IDLE;
      end else begin
         read_ptr   <= read_ptr + PW'(pop);
         commit_ptr <= commit_ptr_d;
         commit_cnt <= commit_cnt_d;
         state_q    <= state_d;
         if (flush_i) begin
            write_ptr <= commit_ptr_d;
            spec_cnt  <= '0;
         end else begin
            write_ptr <= write_ptr + PW'(push);
            spec_cnt  <= spec_cnt + (PW+1)'(push) - (PW+1)'(commit);
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (commit_cnt_d != '0) state_d = REQ;
         REQ:     if (req_port_i.data_gnt) state_d = TAG;
         TAG:     state_d = (commit_cnt_d != '0) ? REQ : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      req_port_o               = '0;
      req_port_o.address_index = head.paddr[11:0];
      req_port_o.address_tag   = head.paddr[55:12];
      req_port_o.data_wdata    = head.data;
      req_port_o.data_be       = head.be;
      req_port_o.data_size     = head.size;
      req_port_o.data_req      = (state_q == REQ);
      req_port_o.data_we       = (state_q == REQ);
      req_port_o.kill_req      = 1'b0;
      req_port_o.tag_valid     = (state_q == TAG);
   end

   // Occupied slots are the run of occupancy entries starting at read_ptr.
   always_comb begin
      page_offset_matches_o = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if ({1'b0, PW'(i) - read_ptr} < occupancy &&
             mem[i].paddr[11:3] == page_offset_i[11:3])
            page_offset_matches_o = 1'b1;
      end
   end

endmodule

// File: tb/tb_store_commit_queue.sv
// Bench for store_commit_queue: directed scenarios and random traffic checked
// against a queue-level model of speculative and committed stores.
module tb_store_commit_queue;
   import ariane_pkg::*;
   import std_cache_pkg::*;

   localparam int DEPTH = 4;

   logic          clk_i = 1'b0;
   logic          rst_i = 1'b1;
   logic          flush_i = 1'b0;
   logic          valid_i = 1'b0;
   logic [55:0]   paddr_i = '0;
   logic [63:0]   data_i = '0;
   logic [7:0]    be_i = '0;
   logic [1:0]    data_size_i = '0;
   logic          ready_o;
   logic          commit_i = 1'b0;
   logic          empty_o;
   logic [11:0]   page_offset_i = '0;
   logic          page_offset_matches_o;
   dcache_req_i_t req_port_o;
   dcache_req_o_t req_port_i = '0;
   logic [1:0]    drain_state_o;

   store_commit_queue #(.DEPTH(DEPTH)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
      .valid_i(valid_i), .paddr_i(paddr_i), .data_i(data_i), .be_i(be_i),
      .data_size_i(data_size_i), .ready_o(ready_o), .commit_i(commit_i),
      .empty_o(empty_o), .page_offset_i(page_offset_i),
      .page_offset_matches_o(page_offset_matches_o),
      .req_port_o(req_port_o), .req_port_i(req_port_i),
      .drain_state_o(drain_state_o)
   );

   always #5 clk_i = ~clk_i;

   // Model: exp_q holds committed stores in drain order (head may be in flight),
   // spec_q holds speculative stores; tag_pend marks a granted head awaiting its tag.
   sq_entry_t exp_q[$];
   sq_entry_t spec_q[$];
   bit        tag_pend;
   int        n_checks = 0;
   int        n_fail = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic sq_entry_t rand_entry();
      sq_entry_t e;
      e.paddr = 56'({$urandom(), $urandom()});
      e.data  = {$urandom(), $urandom()};
      e.be    = 8'($urandom());
      e.size  = 2'($urandom());
      return e;
   endfunction

   function automatic sq_entry_t mk(input logic [55:0] a, input logic [63:0] d);
      sq_entry_t e;
      e.paddr = a; e.data = d; e.be = 8'hFF; e.size = 2'd3;
      return e;
   endfunction

   // One clock cycle: drive at posedge+1, check at negedge, advance model, return at next posedge+1.
   task automatic cycle(input bit v, input sq_entry_t e, input bit c, input bit f,
                        input bit g, input bit r, input logic [11:0] po);
      bit e_ready, e_req, e_empty, e_match;
      valid_i = v; paddr_i = e.paddr; data_i = e.data; be_i = e.be; data_size_i = e.size;
      commit_i = c; flush_i = f; rst_i = r; page_offset_i = po;
      req_port_i.data_gnt    = g;
      req_port_i.data_rvalid = 1'($urandom());
      req_port_i.data_rdata  = {$urandom(), $urandom()};
      #4;
      e_ready = (exp_q.size() + spec_q.size()) < DEPTH;
      e_req   = (exp_q.size() > 0) && !tag_pend;
      e_empty = (exp_q.size() == 0) && (spec_q.size() == 0);
      e_match = 1'b0;
      foreach (exp_q[i])  if (exp_q[i].paddr[11:3] == po[11:3]) e_match = 1'b1;
      foreach (spec_q[i]) if (spec_q[i].paddr[11:3] == po[11:3]) e_match = 1'b1;
      check("ready", ready_o, e_ready);
      check("empty", empty_o, e_empty);
      check("data_req", req_port_o.data_req, e_req);
      check("tag_valid", req_port_o.tag_valid, tag_pend);
      check("match", page_offset_matches_o, e_match);
      if (e_req) begin
         check("index", req_port_o.address_index, exp_q[0].paddr[11:0]);
         check("wdata", req_port_o.data_wdata, exp_q[0].data);
         check("be", req_port_o.data_be, exp_q[0].be);
         check("size", req_port_o.data_size, exp_q[0].size);
         check("we", req_port_o.data_we, 1'b1);
         check("kill", req_port_o.kill_req, 1'b0);
      end
      if (tag_pend) check("tag", req_port_o.address_tag, exp_q[0].paddr[55:12]);
      if (r) begin
         exp_q.delete(); spec_q.delete(); tag_pend = 1'b0;
      end else begin
         if (tag_pend) void'(exp_q.pop_front());
         if (c) exp_q.push_back(spec_q.pop_front());
         if (f) spec_q.delete();
         if (v && e_ready && !f) spec_q.push_back(e);
         tag_pend = e_req && g;
      end
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle(input int n, input bit g);
      for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, 1'b0, g, 1'b0, 12'h000);
   endtask

   initial begin
      sq_entry_t e;
      logic [11:0] po;
      bit c, f;
      repeat (2) @(posedge clk_i);
      #1;
      rst_i = 1'b0;
      tag_pend = 1'b0;

      // Reset state.
      check("rst_ready", ready_o, 1'b1);
      check("rst_empty", empty_o, 1'b1);
      check("rst_req", req_port_o.data_req, 1'b0);
      idle(1, 1'b1);

      // Single store drains with immediate grant: req next cycle, tag the one after.
      cycle(1'b1, mk(56'h80001008, 64'hDEAD), 1'b0, 1'b0, 1'b1, 1'b0, 12'h000);
      cycle(1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0, 12'h000);
      check("d1_req", req_port_o.data_req, 1'b1);
      check("d1_index", req_port_o.address_index, 12'h008);
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 12'h000);
      check("d1_tag_valid", req_port_o.tag_valid, 1'b1);
      check("d1_tag", req_port_o.address_tag, 44'h80001);
      idle(1, 1'b1);
      check("d1_empty", empty_o, 1'b1);

      // Fill, overflow push dropped, flush empties; nothing is ever requested.
      for (int i = 0; i < 4; i++) cycle(1'b1, rand_entry(), 1'b0, 1'b0, 1'b1, 1'b0, 12'h000);
      check("full_ready", ready_o, 1'b0);
      cycle(1'b1, rand_entry(), 1'b0, 1'b0, 1'b1, 1'b0, 12'h000);
      cycle(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000);
      check("flush_ready", ready_o, 1'b1);
      check("flush_empty", empty_o, 1'b1);
      idle(2, 1'b1);

      // A,B,C pushed, A and B committed, flush drops C; A then B drain.
      cycle(1'b1, mk(56'h1000, 64'hA), 1'b0, 1'b0, 1'b1, 1'b0, 12'h000);
      cycle(1'b1, mk(56'h2000, 64'hB), 1'b0, 1'b0, 1'b1, 1'b0, 12'h000);
      cycle(1'b1, mk(56'h3000, 64'hC), 1'b0, 1'b0, 1'b1, 1'b0, 12'h000);
      cycle(1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0, 12'h000);
      cycle(1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0, 12'h000);
      cycle(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000);
      idle(6, 1'b1);
      check("abc_empty", empty_o, 1'b1);

      // Grant withheld for 5 cycles: request fields must hold; tag follows the grant.
      cycle(1'b1, rand_entry(), 1'b0, 1'b0, 1'b0, 1'b0, 12'h000);
      cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000);
      idle(5, 1'b0);
      idle(1, 1'b1);
      check("stall_tag_valid", req_port_o.tag_valid, 1'b1);
      idle(2, 1'b1);

      // Load-forwarding hazard uses paddr[11:3] only.
      cycle(1'b1, mk(56'h70000A38, 64'h5), 1'b0, 1'b0, 1'b1, 1'b0, 12'h000);
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 12'hA3C);
      check("match_hit", page_offset_matches_o, 1'b1);
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 12'hA40);
      check("match_miss", page_offset_matches_o, 1'b0);
      cycle(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000);

      // Reset while in the tag phase with two committed stores.
      cycle(1'b1, rand_entry(), 1'b0, 1'b0, 1'b1, 1'b0, 12'h000);
      cycle(1'b1, rand_entry(), 1'b0, 1'b0, 1'b1, 1'b0, 12'h000);
      cycle(1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0, 12'h000);
      cycle(1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0, 12'h000);
      check("pre_rst_tag", req_port_o.tag_valid, 1'b1);
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000);
      check("rst_mid_req", req_port_o.data_req, 1'b0);
      check("rst_mid_tag", req_port_o.tag_valid, 1'b0);
      check("rst_mid_empty", empty_o, 1'b1);
      check("rst_mid_ready", ready_o, 1'b1);
      idle(1, 1'b1);

      // Random traffic.
      for (int n = 0; n < 400; n++) begin
         e  = rand_entry();
         c  = (spec_q.size() > 0) && ($urandom_range(0, 2) == 0);
         f  = ($urandom_range(0, 15) == 0);
         po = 12'($urandom());
         if ($urandom_range(0, 1) == 1) begin
            if (exp_q.size() > 0) po = exp_q[$urandom_range(0, exp_q.size() - 1)].paddr[11:0];
            else if (spec_q.size() > 0) po = spec_q[$urandom_range(0, spec_q.size() - 1)].paddr[11:0];
         end
         cycle(1'($urandom_range(0, 1)), e, c, f, ($urandom_range(0, 3) != 0), 1'b0, po);
      end
      cycle(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000);
      idle(12, 1'b1);
      check("final_empty", empty_o, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/store_commit_queue.md
STORE_COMMIT_QUEUE -- requirements
Module: store_commit_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4 (power of two, >=2): total entries, speculative plus committed.
REQ-002 SHALL have ports: clk_i  in  1  sole clock; rst_i  in  1  reset, synchronous and active-high.
REQ-003 SHALL have ports: flush_i  in  1  drop all speculative entries.
REQ-004 SHALL have ports: valid_i  in  1, paddr_i  in  56, data_i  in  64, be_i  in  8, data_size_i  in  2  -- speculative store push.
REQ-005 SHALL have ports: ready_o  out  1  push accepted this cycle when high.
REQ-006 SHALL have ports: commit_i  in  1  oldest speculative entry becomes committed.
REQ-007 SHALL have ports: empty_o  out  1  no entries of any kind, no store in flight.
REQ-008 SHALL have ports: page_offset_i  in  12, page_offset_matches_o  out  1  load-forwarding hazard.
REQ-009 SHALL have ports: req_port_o  out  dcache_req_i_t, req_port_i  in  dcache_req_o_t  -- one dcache store request port.

Function
REQ-010 Storage: circular buffer of DEPTH entries; pointers read_ptr, commit_ptr, write_ptr, each log2(DEPTH) bits, wrapping DEPTH-1 -> 0.
REQ-011 Counters: commit_cnt and spec_cnt, each log2(DEPTH)+1 bits; ready_o = (commit_cnt + spec_cnt) < DEPTH, combinational.
REQ-012 Push: valid_i && ready_o && !flush_i writes the entry at write_ptr, write_ptr+1, spec_cnt+1; valid_i while ready_o=0 is dropped.
REQ-013 Commit: commit_i with spec_cnt>0 advances commit_ptr, spec_cnt-1, commit_cnt+1; commit_i with spec_cnt=0 is illegal (bench assertion).
REQ-014 Flush: flush_i sets spec_cnt=0 and write_ptr=commit_ptr (after a same-cycle commit is applied); committed entries and the in-flight drain are untouched.
REQ-015 Same-cycle push+flush: flush wins, the pushed store is lost; same-cycle commit+flush: the commit takes effect, the remaining speculative entries are dropped.
REQ-016 Drain FSM states IDLE, REQ, TAG; IDLE -> REQ when commit_cnt>0.
REQ-017 In REQ: data_req=1, data_we=1, kill_req=0, address_index=paddr[11:0], data_wdata, data_be and data_size from the entry at read_ptr; these are held stable until data_gnt.
REQ-018 In REQ with data_gnt=1: next state TAG.
REQ-019 In TAG (exactly one cycle): tag_valid=1, address_tag=paddr[55:12] of the entry; then read_ptr+1, commit_cnt-1, next state REQ if the remaining commit_cnt>0, else IDLE.
REQ-020 Minimum drain latency: commit on cycle N -> data_req on N+1 -> tag_valid on N+2 (when gnt is immediate); throughput is one store per 2 cycles.
REQ-021 Same-cycle push/commit/pop: all three SHALL apply together with consistent counts; a full queue with a pop in TAG does not raise ready_o until the next cycle.
REQ-022 page_offset_matches_o: combinational OR over every occupied entry (committed, speculative, and in-flight) of paddr[11:3]==page_offset_i[11:3].
REQ-023 empty_o = (commit_cnt==0) && (spec_cnt==0) && state==IDLE.
REQ-024 Outside REQ, data_req=0; outside TAG, tag_valid=0; data_rvalid and data_rdata are ignored.

Reset
REQ-025 rst_i sampled high at a clk_i edge: all pointers and counters 0, state IDLE; entry contents are not reset.
REQ-026 Outputs after reset: ready_o=1, empty_o=1, page_offset_matches_o=0, data_req=0, tag_valid=0.
REQ-027 Reset mid-drain: the request is abandoned immediately, data_req=0 on the next cycle, and all entries, including committed ones, are lost.

Structure
REQ-028 std_cache_pkg SHALL hold typedef sq_entry_t {paddr[55:0], data[63:0], be[7:0], size[1:0]} and a DEFAULT_SQ_DEPTH=4 constant.
REQ-029 dcache_req_i_t and dcache_req_o_t SHALL come from ariane_pkg.
REQ-030 No sub-module; the buffer, counters and 3-state FSM are implemented inline.

Verification
REQ-031 Push paddr=0x80001008, data=0xDEAD, be=0xFF, then commit, gnt tied 1 -> data_req with index 0x008 on the next cycle, then tag_valid with tag 0x80001, then empty_o=1.
REQ-032 Push 4 entries, no commit -> ready_o=0; a 5th push is ignored; flush_i -> ready_o=1 and empty_o=1 one cycle later, and data_req is never asserted.
REQ-033 Push A,B,C; commit A,B; flush -> exactly A then B are drained in order, C is never issued.
REQ-034 Hold gnt=0 for 5 cycles in REQ -> data_req and all request fields stay stable; gnt on cycle 6 -> tag_valid on cycle 7.
REQ-035 Entry with paddr 0x...0A38 queued; page_offset_i=0xA3C -> match=1; page_offset_i=0xA40 -> match=0.
REQ-036 Assert rst_i while in TAG with 2 committed entries -> next cycle data_req=0, tag_valid=0, empty_o=1, ready_o=1.
